// File: rtl/vld_data_pipe.sv
// Valid/ready register pipeline with per-stage bubble collapse and flush.
// Define VLD_DATA_PIPE_OCC_CNT_EN to build the occupancy counter; otherwise occ_cnt is tied to 0.
module vld_data_pipe #(
  parameter int PIPE_NUM = 4,
  parameter int DATA_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [DATA_W-1:0]             out_data,
  output logic [PIPE_NUM-1:0]           vld_d,
  output logic [$clog2(PIPE_NUM+1)-1:0] occ_cnt
);

  logic [PIPE_NUM-1:0] vld_reg;
  logic [PIPE_NUM-1:0] stage_rdy;
  logic [PIPE_NUM-1:0] src_vld;
  logic [DATA_W-1:0]   data_reg [PIPE_NUM];
  logic                in_xfer;

  // A stage can take new content if it is empty or its occupant moves on this cycle.
  always_comb begin
    stage_rdy = '0;
    stage_rdy[PIPE_NUM-1] = ~vld_reg[PIPE_NUM-1] | out_rdy;
    for (int k = PIPE_NUM - 2; k >= 0; k--) begin
      stage_rdy[k] = ~vld_reg[k] | stage_rdy[k+1];
    end
  end

  assign in_rdy  = stage_rdy[0] & ~flush & ~rst;
  assign out_vld = vld_reg[PIPE_NUM-1] & ~rst;
  assign in_xfer = in_vld & in_rdy;

  always_comb begin
    src_vld    = '0;
    src_vld[0] = in_xfer;
    for (int k = 1; k < PIPE_NUM; k++) begin
      src_vld[k] = vld_reg[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_reg <= '0;
    end else begin
      for (int k = 0; k < PIPE_NUM; k++) begin
        if (stage_rdy[k]) begin
          vld_reg[k] <= src_vld[k];
        end
      end
    end
  end

  // Payload registers carry no reset and only load real payloads.
  generate
    for (genvar gi = 0; gi < PIPE_NUM; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!flush && stage_rdy[gi] && src_vld[gi]) begin
            data_reg[gi] <= in_data;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (!flush && stage_rdy[gi] && src_vld[gi]) begin
            data_reg[gi] <= data_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_data = data_reg[PIPE_NUM-1];
  assign vld_d    = vld_reg;

`ifdef VLD_DATA_PIPE_OCC_CNT_EN
  localparam int CNT_W = $clog2(PIPE_NUM + 1);
  logic             out_xfer;
  logic [CNT_W-1:0] occ_cnt_reg;

  assign out_xfer = out_vld & out_rdy;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_cnt_reg <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ_cnt_reg <= occ_cnt_reg + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_cnt_reg <= occ_cnt_reg - CNT_W'(1);
    end
  end

  assign occ_cnt = occ_cnt_reg;
`else
  assign occ_cnt = '0;
`endif

endmodule

// File: doc/vld_data_pipe.md
VLD_DATA_PIPE -- requirements
Module: vld_data_pipe

Interface
REQ-001 SHALL have parameter PIPE_NUM, default 4, number of register stages (legal 1..32).
REQ-002 SHALL have parameter DATA_W, default 32, payload width in bits (legal 1..1024).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all stage contents.
REQ-006 SHALL have port in_vld  input  1  upstream payload valid.
REQ-007 SHALL have port in_rdy  output  1  pipe accepts payload this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL have port out_vld  output  1  stage PIPE_NUM-1 holds a payload.
REQ-010 SHALL have port out_rdy  input  1  downstream accepts payload.
REQ-011 SHALL have port out_data  output  DATA_W  payload of last stage.
REQ-012 SHALL have port vld_d  output  PIPE_NUM  per-stage valid bit, bit 0 = first stage.
REQ-013 SHALL have port occ_cnt  output  $clog2(PIPE_NUM+1)  number of occupied stages.

Function
REQ-014 Stage k SHALL be ready when vld_d[k]==0 or stage k+1 is ready; last stage ready = ~vld_d[PIPE_NUM-1] | out_rdy.
REQ-015 in_rdy SHALL equal stage-0 ready AND ~flush (combinational, no register).
REQ-016 Input transfer SHALL occur on in_vld & in_rdy; output transfer on out_vld & out_rdy.
REQ-017 Each stage SHALL load from its predecessor (stage 0 from in_data/in_vld) only when that stage is ready; otherwise SHALL hold valid and data.
REQ-018 Bubbles SHALL collapse: an empty stage SHALL accept data even while downstream is stalled.
REQ-019 With out_rdy held 1, latency in_vld->out_vld SHALL be exactly PIPE_NUM cycles, throughput 1 payload/cycle.
REQ-020 Data registers SHALL update only when the incoming valid bit is 1 (no load of invalid payload).
REQ-021 Payload order SHALL be preserved; no payload SHALL be dropped or duplicated except by flush/rst.
REQ-022 out_data SHALL be stage PIPE_NUM-1 data register directly; value undefined-but-stable when out_vld==0.
REQ-023 flush==1 SHALL clear all vld_d bits at the next edge; in_rdy==0 that cycle; data registers unchanged.
REQ-024 flush simultaneous with out_vld&out_rdy SHALL still count the output transfer as completed.
REQ-025 When all stages full and out_rdy==0, in_rdy SHALL be 0 and state SHALL be frozen.
REQ-026 Full pipe with out_rdy==1 and in_vld==1 SHALL shift in and out same cycle, occupancy unchanged.
REQ-027 PIPE_NUM==1 SHALL reduce to a single register slice obeying REQ-014..026.

Reset
REQ-028 rst==1 at an edge SHALL clear vld_d to 0 and occ_cnt to 0; rst dominates flush and in_vld.
REQ-029 During rst, out_vld SHALL be 0 and in_rdy SHALL be 0.
REQ-030 Data registers SHALL NOT be reset.
REQ-031 Reset mid-stream SHALL lose all in-flight payloads; first post-reset input SHALL emerge after PIPE_NUM cycles.

Configuration
REQ-032 Macro VLD_DATA_PIPE_OCC_CNT_EN defined: occ_cnt SHALL be a register updated each cycle to +1 on input-only transfer, -1 on output-only transfer, unchanged on both/neither, 0 on flush or rst.
REQ-033 Macro undefined: occ_cnt port SHALL remain and be tied to 0; no counter logic.
REQ-034 With macro defined, occ_cnt SHALL always equal popcount(vld_d) and never exceed PIPE_NUM.

Verification
REQ-035 PIPE_NUM=4, out_rdy=1, in_vld=1 for 8 cycles, data 0x10..0x17 -> out_vld rises cycle 4, out_data 0x10..0x17 consecutive.
REQ-036 Fill 4 stages with out_rdy=0 -> in_rdy=0, vld_d=4'b1111, occ_cnt=4; release out_rdy -> in_rdy=1 same cycle.
REQ-037 Single payload 0xA5 then out_rdy=0 -> 0xA5 parks at stage 3; next 3 inputs fill stages 2..0 (bubble collapse), order A5,x,y,z on release.
REQ-038 Pipe half full (vld_d=4'b0101), flush=1 with in_vld=1 -> next cycle vld_d=0, occ_cnt=0, in_vld payload not captured.
REQ-039 rst=1 for 1 cycle while full and streaming -> vld_d=0, out_vld=0; next input out after 4 cycles.
REQ-040 Random in_vld/out_rdy 10k cycles, PIPE_NUM in {1,3,8}, DATA_W=8 -> scoreboard in-order match, occ_cnt==popcount(vld_d) with macro on, 0 with macro off.
